// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - data-memory handshake between hazard controller and memory
interface pipe_hazard_ctrl_if;
    logic mem_req;
    logic mem_ready;

    modport master (output mem_req, input mem_ready);
    modport slave  (input mem_req, output mem_ready);
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush controller for the 5-stage pipeline
// Load-use, taken-branch and multi-cycle memory hazards with timeout and stall counter.
module pipe_hazard_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [4:0]                RsD,
    input  logic [4:0]                RtD,
    input  logic                      RegWriteE,
    input  logic                      MemtoRegE,
    input  logic [4:0]                WriteRegE,
    input  logic                      MemtoRegM,
    input  logic                      MemWriteM,
    input  logic                      BranchTakenD,
    pipe_hazard_ctrl_if.master        mem,
    output logic                      StallF,
    output logic                      StallD,
    output logic                      StallE,
    output logic                      StallM,
    output logic                      FlushD,
    output logic                      FlushE,
    output logic                      FlushW,
    output logic                      mem_err,
    output logic [31:0]               stall_cycles
);

    typedef enum logic [1:0] {RUN, MEM_WAIT, ERR} state_t;

    localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    logic             memacc;
    logic             req_int;
    logic             memstall;
    logic             lu;

    always_comb begin
        memacc   = MemtoRegM | MemWriteM;
        req_int  = memacc & (state != ERR);
        memstall = req_int & ~mem.mem_ready;
        lu       = RegWriteE & MemtoRegE & (WriteRegE != 5'd0) &
                   ((WriteRegE == RsD) | (WriteRegE == RtD));
    end

    // Priority chain ERR > memstall > load-use > branch; everything is held low in reset.
    always_comb begin
        mem.mem_req = req_int & rst_n;
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (rst_n) begin
            if ((state == ERR) || memstall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (lu) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end else if (BranchTakenD) begin
                FlushD = 1'b1;
            end
        end
    end

    // wait_cnt holds the number of wait cycles already spent on the current access,
    // so the first stalled cycle in RUN loads 1 and ERR follows TIMEOUT+1 wait cycles.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RUN;
            wait_cnt <= '0;
            mem_err  <= 1'b0;
        end else begin
            case (state)
                RUN: begin
                    if (memstall) begin
                        state    <= MEM_WAIT;
                        wait_cnt <= CNT_W'(1);
                    end else begin
                        wait_cnt <= '0;
                    end
                end
                MEM_WAIT: begin
                    if (mem.mem_ready) begin
                        state    <= RUN;
                        wait_cnt <= '0;
                    end else if (wait_cnt == TO_CNT) begin
                        state   <= ERR;
                        mem_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                ERR: begin
                    state   <= ERR;
                    mem_err <= 1'b1;
                end
                default: begin
                    state    <= RUN;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cycles <= '0;
        end else if (StallF && (stall_cycles != 32'hFFFF_FFFF)) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb/tb_pipe_hazard_ctrl.sv - self-checking bench for pipe_hazard_ctrl
module tb_pipe_hazard_ctrl;
    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  RsD = '0, RtD = '0, WriteRegE = '0;
    logic        RegWriteE = 1'b0, MemtoRegE = 1'b0;
    logic        MemtoRegM = 1'b0, MemWriteM = 1'b0, BranchTakenD = 1'b0;
    logic        StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
    logic [31:0] stall_cycles;

    pipe_hazard_ctrl_if mif();

    pipe_hazard_ctrl #(.TIMEOUT(TIMEOUT), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .RsD(RsD), .RtD(RtD),
        .RegWriteE(RegWriteE), .MemtoRegE(MemtoRegE), .WriteRegE(WriteRegE),
        .MemtoRegM(MemtoRegM), .MemWriteM(MemWriteM), .BranchTakenD(BranchTakenD),
        .mem(mif),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW),
        .mem_err(mem_err), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: an access errors out once it has spent TIMEOUT+1 cycles stalled.
    bit          m_err;
    int          m_waited;
    logic [31:0] m_stalls;

    function automatic logic [7:0] model_out();
        logic req, ms, lu;
        req = (MemtoRegM | MemWriteM) & ~m_err;
        ms  = req & ~mif.mem_ready;
        lu  = RegWriteE & MemtoRegE & (WriteRegE != 0) & ((WriteRegE == RsD) | (WriteRegE == RtD));
        // bit order: mem_req StallF StallD StallE StallM FlushD FlushE FlushW
        if (m_err || ms)       return {req, 7'b1111001};
        else if (lu)           return {req, 7'b1100010};
        else if (BranchTakenD) return {req, 7'b0000100};
        else                   return {req, 7'b0000000};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_err    = 1'b0;
            m_waited = 0;
            m_stalls = '0;
        end else begin
            logic [7:0] o;
            o = model_out();
            if (o[6] && m_stalls != 32'hFFFF_FFFF) m_stalls = m_stalls + 1;
            if (!m_err) begin
                if (o[7] && !mif.mem_ready) begin
                    m_waited++;
                    if (m_waited == TIMEOUT + 1) m_err = 1'b1;
                end else begin
                    m_waited = 0;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("outputs_vs_model",
                  {24'd0, mif.mem_req, StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW},
                  {24'd0, model_out()});
            check("mem_err_vs_model", {31'd0, mem_err}, {31'd0, m_err});
            check("stall_cycles_vs_model", stall_cycles, m_stalls);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        RsD = '0; RtD = '0; WriteRegE = '0;
        RegWriteE = 1'b0; MemtoRegE = 1'b0;
        MemtoRegM = 1'b0; MemWriteM = 1'b0; BranchTakenD = 1'b0;
        mif.mem_ready = 1'b0;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle();
        rst_n = 1'b0;
        MemtoRegM = 1'b1;
        #2;
        check("reset_mem_req", {31'd0, mif.mem_req}, 32'd0);
        check("reset_stallF", {31'd0, StallF}, 32'd0);
        check("reset_stall_cycles", stall_cycles, 32'd0);
        check("reset_mem_err", {31'd0, mem_err}, 32'd0);
        idle();
        cyc(); cyc();
        rst_n = 1'b1;

        // load-use on RsD
        RegWriteE = 1'b1; MemtoRegE = 1'b1; WriteRegE = 5'd8; RsD = 5'd8;
        #2;
        check("lu_stallF", {31'd0, StallF}, 32'd1);
        check("lu_flushE", {31'd0, FlushE}, 32'd1);
        check("lu_stallE", {31'd0, StallE}, 32'd0);
        cyc(); idle();
        check("lu_stall_cycles", stall_cycles, 32'd1);

        // destination $0 never hazards
        RegWriteE = 1'b1; MemtoRegE = 1'b1; WriteRegE = 5'd0; RsD = 5'd0;
        #2;
        check("lu_r0_stallF", {31'd0, StallF}, 32'd0);
        cyc(); idle();

        // branch alone, then branch under load-use on RtD
        BranchTakenD = 1'b1;
        #2;
        check("br_flushD", {31'd0, FlushD}, 32'd1);
        check("br_stallF", {31'd0, StallF}, 32'd0);
        RegWriteE = 1'b1; MemtoRegE = 1'b1; WriteRegE = 5'd9; RtD = 5'd9;
        #1;
        check("br_lu_flushD", {31'd0, FlushD}, 32'd0);
        check("br_lu_flushE", {31'd0, FlushE}, 32'd1);
        cyc(); idle();
        check("br_lu_stall_cycles", stall_cycles, 32'd2);

        // three wait cycles then completion
        MemtoRegM = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mw_stallM", {31'd0, StallM}, 32'd1);
            check("mw_flushW", {31'd0, FlushW}, 32'd1);
            cyc();
        end
        mif.mem_ready = 1'b1;
        #1;
        check("mw_done_stallF", {31'd0, StallF}, 32'd0);
        check("mw_done_req", {31'd0, mif.mem_req}, 32'd1);
        cyc(); idle();
        check("mw_stall_cycles", stall_cycles, 32'd5);

        // single-cycle access, then ready without request
        MemWriteM = 1'b1; mif.mem_ready = 1'b1;
        #1;
        check("fast_stallF", {31'd0, StallF}, 32'd0);
        cyc(); idle();
        mif.mem_ready = 1'b1;
        cyc(); idle();
        check("fast_stall_cycles", stall_cycles, 32'd5);

        // memstall masks load-use and branch
        MemtoRegM = 1'b1; BranchTakenD = 1'b1;
        RegWriteE = 1'b1; MemtoRegE = 1'b1; WriteRegE = 5'd3; RsD = 5'd3;
        #1;
        check("prio_flushE", {31'd0, FlushE}, 32'd0);
        check("prio_flushD", {31'd0, FlushD}, 32'd0);
        check("prio_stallE", {31'd0, StallE}, 32'd1);
        cyc();

        // asynchronous reset while waiting
        #1;
        rst_n = 1'b0;
        #1;
        check("mid_rst_mem_req", {31'd0, mif.mem_req}, 32'd0);
        check("mid_rst_stallF", {31'd0, StallF}, 32'd0);
        check("mid_rst_flushW", {31'd0, FlushW}, 32'd0);
        check("mid_rst_stall_cycles", stall_cycles, 32'd0);
        idle();
        cyc();
        rst_n = 1'b1;

        // timeout: five wait cycles before ERR
        MemWriteM = 1'b1;
        for (int i = 0; i < 4; i++) cyc();
        check("to_not_yet", {31'd0, mem_err}, 32'd0);
        cyc();
        check("to_mem_err", {31'd0, mem_err}, 32'd1);
        check("to_mem_req", {31'd0, mif.mem_req}, 32'd0);
        check("to_stallF", {31'd0, StallF}, 32'd1);
        check("to_stall_cycles", stall_cycles, 32'd5);
        mif.mem_ready = 1'b1;
        cyc();
        check("to_ready_ignored", {31'd0, mem_err}, 32'd1);
        check("to_still_stalled", {31'd0, StallM}, 32'd1);

        // reset leaves ERR
        #1;
        rst_n = 1'b0;
        idle();
        cyc();
        rst_n = 1'b1;
        MemtoRegM = 1'b1; mif.mem_ready = 1'b1;
        #1;
        check("post_err_mem_req", {31'd0, mif.mem_req}, 32'd1);
        check("post_err_stallF", {31'd0, StallF}, 32'd0);
        cyc(); idle();
        cyc();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
